// File: rtl/mipi_dsi_packet_assembler_if.sv
`default_nettype none
// ============================================================================
// mipi_dsi_packet_assembler_if : HS byte input and assembled-word output bus
// Rev 1.0
// ============================================================================
interface mipi_dsi_packet_assembler_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_active;
  logic [31:0] packet;
  logic        packet_valid;
  logic        packet_header;
  logic        trunc_err;
  logic        ecc_err;

  modport master (
    output rx_data, rx_valid, rx_active,
    input  packet, packet_valid, packet_header, trunc_err, ecc_err
  );

  modport slave (
    input  rx_data, rx_valid, rx_active,
    output packet, packet_valid, packet_header, trunc_err, ecc_err
  );
endinterface
`default_nettype wire

// File: rtl/mipi_dsi_packet_assembler.sv
`default_nettype none
// ============================================================================
// mipi_dsi_packet_assembler : DSI HS byte stream -> 32-bit header/payload words
// Optional header ECC check via macro DSI_ECC_CHECK_EN.   Rev 1.0
// ============================================================================
module mipi_dsi_packet_assembler (
  input logic                         clk,
  input logic                         rst,
  mipi_dsi_packet_assembler_if.slave  bus
);

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    PAYLOAD = 2'd1,
    CRC     = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  byte_cnt, byte_cnt_nxt;
  logic [15:0] remain, remain_nxt;
  logic [31:0] word_buf, word_buf_nxt;
  logic [31:0] packet_q, packet_nxt;
  logic        valid_q, valid_nxt;
  logic        header_q, header_nxt;
  logic        trunc_q, trunc_nxt;

  logic [31:0] merged;
  logic [15:0] wc;
  logic        is_long;
  logic        hdr_ok;

  // Incoming byte lands in lane (3 - byte_cnt); lower lanes stay zero for padding.
  assign merged  = word_buf | ({24'h0, bus.rx_data} << {~byte_cnt, 3'b000});
  assign wc      = {merged[15:8], merged[23:16]};
  assign is_long = (merged[27:24] == 4'h9) || (merged[27:24] == 4'hC) ||
                   (merged[27:24] == 4'hD) || (merged[27:24] == 4'hE);

`ifdef DSI_ECC_CHECK_EN
  logic [23:0] ecc_d;
  logic [5:0]  ecc_calc;
  logic        ecc_q, ecc_nxt;

  assign ecc_d = {merged[15:8], merged[23:16], merged[31:24]};
  assign ecc_calc[0] = ecc_d[0]  ^ ecc_d[1]  ^ ecc_d[2]  ^ ecc_d[4]  ^ ecc_d[5]  ^ ecc_d[7]  ^
                       ecc_d[10] ^ ecc_d[11] ^ ecc_d[13] ^ ecc_d[16] ^ ecc_d[20] ^ ecc_d[21] ^
                       ecc_d[22] ^ ecc_d[23];
  assign ecc_calc[1] = ecc_d[0]  ^ ecc_d[1]  ^ ecc_d[3]  ^ ecc_d[4]  ^ ecc_d[6]  ^ ecc_d[8]  ^
                       ecc_d[10] ^ ecc_d[12] ^ ecc_d[14] ^ ecc_d[17] ^ ecc_d[20] ^ ecc_d[21] ^
                       ecc_d[22] ^ ecc_d[23];
  assign ecc_calc[2] = ecc_d[0]  ^ ecc_d[2]  ^ ecc_d[3]  ^ ecc_d[5]  ^ ecc_d[6]  ^ ecc_d[9]  ^
                       ecc_d[11] ^ ecc_d[12] ^ ecc_d[15] ^ ecc_d[18] ^ ecc_d[20] ^ ecc_d[21] ^
                       ecc_d[22];
  assign ecc_calc[3] = ecc_d[1]  ^ ecc_d[2]  ^ ecc_d[3]  ^ ecc_d[7]  ^ ecc_d[8]  ^ ecc_d[9]  ^
                       ecc_d[13] ^ ecc_d[14] ^ ecc_d[15] ^ ecc_d[19] ^ ecc_d[20] ^ ecc_d[21] ^
                       ecc_d[23];
  assign ecc_calc[4] = ecc_d[4]  ^ ecc_d[5]  ^ ecc_d[6]  ^ ecc_d[7]  ^ ecc_d[8]  ^ ecc_d[9]  ^
                       ecc_d[16] ^ ecc_d[17] ^ ecc_d[18] ^ ecc_d[19] ^ ecc_d[20] ^ ecc_d[22] ^
                       ecc_d[23];
  assign ecc_calc[5] = ecc_d[10] ^ ecc_d[11] ^ ecc_d[12] ^ ecc_d[13] ^ ecc_d[14] ^ ecc_d[15] ^
                       ecc_d[16] ^ ecc_d[17] ^ ecc_d[18] ^ ecc_d[19] ^ ecc_d[21] ^ ecc_d[22] ^
                       ecc_d[23];
  assign hdr_ok      = (merged[7:0] == {2'b00, ecc_calc});
  assign bus.ecc_err = ecc_q;
`else
  assign hdr_ok      = 1'b1;
  assign bus.ecc_err = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    remain_nxt   = remain;
    word_buf_nxt = word_buf;
    packet_nxt   = packet_q;
    valid_nxt    = 1'b0;
    header_nxt   = 1'b0;
    trunc_nxt    = 1'b0;
`ifdef DSI_ECC_CHECK_EN
    ecc_nxt      = 1'b0;
`endif
    if (!bus.rx_active) begin
      // End of burst: anything other than a clean packet boundary is truncation.
      trunc_nxt    = !((state == DISCARD) || ((state == HDR) && (byte_cnt == 2'd0)));
      state_nxt    = HDR;
      byte_cnt_nxt = 2'd0;
      remain_nxt   = 16'd0;
      word_buf_nxt = 32'h0;
    end else if (bus.rx_valid) begin
      case (state)
        HDR: begin
          if (byte_cnt != 2'd3) begin
            word_buf_nxt = merged;
            byte_cnt_nxt = byte_cnt + 2'd1;
          end else begin
            byte_cnt_nxt = 2'd0;
            word_buf_nxt = 32'h0;
            if (!hdr_ok) begin
              state_nxt = DISCARD;
`ifdef DSI_ECC_CHECK_EN
              ecc_nxt   = 1'b1;
`endif
            end else begin
              packet_nxt = merged;
              valid_nxt  = 1'b1;
              header_nxt = 1'b1;
              if (!is_long) begin
                state_nxt = HDR;
              end else if (wc == 16'd0) begin
                state_nxt = CRC;
              end else begin
                state_nxt  = PAYLOAD;
                remain_nxt = wc;
              end
            end
          end
        end
        PAYLOAD: begin
          remain_nxt = remain - 16'd1;
          if ((byte_cnt == 2'd3) || (remain == 16'd1)) begin
            packet_nxt   = merged;
            valid_nxt    = 1'b1;
            byte_cnt_nxt = 2'd0;
            word_buf_nxt = 32'h0;
          end else begin
            word_buf_nxt = merged;
            byte_cnt_nxt = byte_cnt + 2'd1;
          end
          if (remain == 16'd1) begin
            state_nxt = CRC;
          end
        end
        CRC: begin
          if (byte_cnt == 2'd1) begin
            state_nxt    = HDR;
            byte_cnt_nxt = 2'd0;
          end else begin
            byte_cnt_nxt = 2'd1;
          end
        end
        DISCARD: begin
          state_nxt = DISCARD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HDR;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= 2'd0;
      remain   <= 16'd0;
      word_buf <= 32'h0;
      packet_q <= 32'h0;
      valid_q  <= 1'b0;
      header_q <= 1'b0;
      trunc_q  <= 1'b0;
`ifdef DSI_ECC_CHECK_EN
      ecc_q    <= 1'b0;
`endif
    end else begin
      byte_cnt <= byte_cnt_nxt;
      remain   <= remain_nxt;
      word_buf <= word_buf_nxt;
      packet_q <= packet_nxt;
      valid_q  <= valid_nxt;
      header_q <= header_nxt;
      trunc_q  <= trunc_nxt;
`ifdef DSI_ECC_CHECK_EN
      ecc_q    <= ecc_nxt;
`endif
    end
  end

  assign bus.packet        = packet_q;
  assign bus.packet_valid  = valid_q;
  assign bus.packet_header = header_q;
  assign bus.trunc_err     = trunc_q;

endmodule
`default_nettype wire

// File: doc/mipi_dsi_packet_assembler.md
MIPI_DSI_PACKET_ASSEMBLER -- requirements
Module: mipi_dsi_packet_assembler

Interface
REQ-001 SHALL have port clk, input, 1: rising-edge clock for all logic.
REQ-002 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have port rx_data, input, 8: HS byte from the lane merger, first byte of a burst first.
REQ-004 SHALL have port rx_valid, input, 1: rx_data is valid this cycle; it may drop for any number of cycles mid-burst (stall).
REQ-005 SHALL have port rx_active, input, 1: high for the duration of an HS burst; a fall marks EoT.
REQ-006 SHALL have port packet, output, 32: assembled word; the first received byte is at [31:24].
REQ-007 SHALL have port packet_valid, output, 1: one-cycle strobe qualifying packet.
REQ-008 SHALL have port packet_header, output, 1: the word on packet is a packet header; valid only with packet_valid.
REQ-009 SHALL have port trunc_err, output, 1: one-cycle pulse when a burst ends mid-packet.
REQ-010 SHALL have port ecc_err, output, 1: one-cycle pulse on header ECC mismatch; tied 0 when DSI_ECC_CHECK_EN is undefined.

Function
REQ-011 States SHALL be: HDR (collect 4 header bytes), PAYLOAD, CRC (skip 2 bytes), DISCARD (drop bytes until rx_active falls).
REQ-012 Bytes SHALL be consumed only when rx_valid=1 and rx_active=1; a byte with rx_active=0 SHALL be ignored.
REQ-013 Header byte order SHALL be DI, WC_lo, WC_hi, ECC, giving header word {DI, WC_lo, WC_hi, ECC}.
   - DT = packet[29:24].
   - WC = {packet[15:8], packet[23:16]}.
REQ-014 A packet SHALL be long iff DT[3:0] is one of 4'h9, 4'hC, 4'hD, 4'hE; all other DTs SHALL be short.
REQ-015 Each completed word SHALL appear with packet_valid=1 exactly one cycle after the clock edge that accepts its last byte (latency 1).
REQ-016 The header word SHALL always be emitted with packet_header=1; payload words SHALL be emitted with packet_header=0.
REQ-017 Short packet: after the header, the next state SHALL be HDR.
REQ-018 Long packet, WC>0: the next state SHALL be PAYLOAD, with a 16-bit remaining-byte counter loaded with WC.
REQ-019 Long packet, WC=0: the next state SHALL be CRC.
REQ-020 In PAYLOAD, a word SHALL be emitted after every 4th byte or after the last byte, whichever comes first.
   - A partial final word SHALL be zero-padded in its low-order bytes (WC=5 gives words b0b1b2b3 and b4,00,00,00).
REQ-021 The counter SHALL decrement per accepted payload byte; on reaching 0 the next state SHALL be CRC.
   - WC=16'hFFFF SHALL be handled without overflow.
REQ-022 CRC SHALL consume 2 bytes without checking or emitting them, then go to HDR.
REQ-023 If rx_active falls while in HDR with 0 bytes collected: return to HDR with no error.
REQ-024 If rx_active falls anywhere else (HDR with 1-3 bytes, PAYLOAD, CRC): pulse trunc_err for one cycle, discard the partial word, go to HDR.
REQ-025 DISCARD SHALL exit to HDR when rx_active falls, without raising trunc_err.
REQ-026 At most one word SHALL be emitted per cycle; packet SHALL hold its last value while packet_valid=0.

Reset
REQ-027 rst SHALL force: state=HDR, byte and word counters=0, packet=32'h0, packet_valid=0, packet_header=0, trunc_err=0, ecc_err=0.
REQ-028 rst asserted mid-packet SHALL drop the packet in progress with no strobe and no error pulse.
   - The first byte accepted after reset release SHALL be treated as DI.
REQ-029 rst SHALL take priority over every other input in the same cycle.

Configuration
REQ-030 With macro DSI_ECC_CHECK_EN defined: ECC SHALL be computed over D[23:0] = {WC_hi, WC_lo, DI} using the MIPI DSI 6-bit Hamming code, with expected ECC[7:6]=0.
   - On mismatch: no header emitted, ecc_err pulses one cycle after the 4th header byte, state goes to DISCARD.
   - No single-bit correction SHALL be performed.
REQ-031 With DSI_ECC_CHECK_EN undefined: the ECC byte SHALL be passed through unchecked and no ECC logic SHALL be synthesised.

Verification
REQ-032 Short packet 01 00 00 07 -> one strobe: packet=32'h01000007, packet_header=1.
REQ-033 Long RGB565 packet DT 0x0E, WC=6: bytes 0E 06 00 ECC, AA BB CC DD EE FF, CRC CRC -> three strobes.
   - Header word 32'h0E0600xx, then 32'hAABBCCDD, then 32'hEEFF0000 (packet_header=0 on both payload words); the CRC bytes are not emitted.
REQ-034 The REQ-033 burst with rx_valid toggled every other cycle -> identical words; each strobe 1 cycle after its last byte.
REQ-035 rx_active dropped after 2 payload bytes of a WC=8 packet -> trunc_err pulses once, no payload strobe; the next burst 01 00 00 07 parses correctly.
REQ-036 DSI_ECC_CHECK_EN defined, header 21 00 00 3F (corrupted ECC) -> ecc_err pulse, no strobe, remaining burst bytes ignored.
   - The same header with correct ECC 21 00 00 12 -> one header strobe.
